// File: rtl/div_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_if;
    logic        signed_div_i;
    logic [31:0] operand_1_i;
    logic [31:0] operand_2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, operand_1_i, operand_2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, operand_1_i, operand_2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// 32-iteration restoring divider for DIV/DIVU; result is {remainder, quotient}
// and is held with ready_o until the requester drops start_i.
module div_unit (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [64:0] shift_d;
    logic [32:0] trial_d;
    logic [64:0] step_d;
    logic [63:0] fix_d;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // 0x80000000 negates to itself and is then read as an unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[31]);
    endfunction

    always_comb begin
        shift_d = work_q << 1;
        trial_d = shift_d[64:32] - {1'b0, divisor_q};
        step_d  = trial_d[32] ? shift_d : {trial_d, shift_d[31:1], 1'b1};
        fix_d   = {cond_neg(step_d[63:32], neg_rem_q), cond_neg(step_d[31:0], neg_quo_q)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            ready_q  <= 1'b0;
            result_q <= 64'd0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        divisor_q <= magnitude(bus.operand_2_i, bus.signed_div_i);
                        work_q    <= {33'd0, magnitude(bus.operand_1_i, bus.signed_div_i)};
                        neg_quo_q <= bus.signed_div_i & (bus.operand_1_i[31] ^ bus.operand_2_i[31]);
                        neg_rem_q <= bus.signed_div_i & bus.operand_1_i[31];
                        cnt_q     <= 5'd0;
                        state_q   <= (bus.operand_2_i == 32'd0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    work_q  <= 65'd0;
                    state_q <= bus.annul_i ? IDLE : END;
                end
                ON: begin
                    if (bus.annul_i) begin
                        state_q <= IDLE;
                        cnt_q   <= 5'd0;
                        work_q  <= 65'd0;
                    end else if (cnt_q == 5'd31) begin
                        // Final iteration: store the sign-corrected result for END to present.
                        work_q  <= {1'b0, fix_d};
                        cnt_q   <= 5'd0;
                        state_q <= END;
                    end else begin
                        work_q <= step_d;
                        cnt_q  <= cnt_q + 5'd1;
                    end
                end
                END: begin
                    if (bus.start_i) begin
                        ready_q  <= 1'b1;
                        result_q <= work_q[63:0];
                    end else begin
                        state_q <= IDLE;
                        work_q  <= 65'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, randomized runs against an
// arithmetic reference, and annul/reset sequences.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero;
    // remainder carries the dividend's sign, zero divisor gives all zeros.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input string nm,
                           input bit scramble);
        int n;
        bus.signed_div_i = s;
        bus.operand_1_i  = a;
        bus.operand_2_i  = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        @(posedge clk); #1;
        if (scramble) begin
            bus.operand_1_i  = $urandom;
            bus.operand_2_i  = $urandom;
            bus.signed_div_i = ~s;
        end
        n = 0;
        while (!bus.ready_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " result"}, bus.result_o, exp);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " held ready"}, 64'(bus.ready_o), 64'd1);
        chk({nm, " held result"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        chk({nm, " drop ready"}, 64'(bus.ready_o), 64'd0);
        chk({nm, " drop result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit          s;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                 33, "u100/7"};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},    33, "s-7/2"};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},    33, "s7/-2"};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0, 32'h80000000},           33, "smin/-1"};
        vecs[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h0},           33, "u8000/ffff"};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0, 32'hFFFFFFFF},           33, "umax/1"};
        vecs[6] = '{1'b0, 32'd1234,       32'd0,        64'd0,                           2,  "u1234/0"};
        vecs[7] = '{1'b1, 32'hFFFFFF00,   32'd0,        64'd0,                           2,  "sneg/0"};

        bus.signed_div_i = 1'b0;
        bus.operand_1_i  = 32'd0;
        bus.operand_2_i  = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b0);

        // Annul on the 10th ON cycle, then annul held in IDLE must block a pending start
        bus.signed_div_i = 1'b0;
        bus.operand_1_i  = 32'd100;
        bus.operand_2_i  = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        chk("annul ready", 64'(bus.ready_o), 64'd0);
        chk("annul result", bus.result_o, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("annul idle ready", 64'(bus.ready_o), 64'd0);
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, "after annul 50/5", 1'b0);

        // Reset during iteration 20 with operand churn
        bus.signed_div_i = 1'b0;
        bus.operand_1_i  = 32'd100;
        bus.operand_2_i  = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1;
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.operand_1_i  = $urandom;
        bus.operand_2_i  = $urandom;
        @(posedge clk); #1;
        chk("midrst ready", 64'(bus.ready_o), 64'd0);
        chk("midrst result", bus.result_o, 64'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("post rst idle ready", 64'(bus.ready_o), 64'd0);
        chk("post rst idle result", bus.result_o, 64'd0);
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7), 33, "post rst s-100/7", 1'b1);

        // Randomized operands, scrambled after acceptance
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            run_div(s, a, b, model(s, a, b), (b == 32'd0) ? 2 : 33,
                    $sformatf("rand%0d %s %h/%h", i, s ? "s" : "u", a, b), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. Accepts a start request with operands and a signedness flag, runs a 32-iteration restoring shift-subtract division, and returns a 64-bit result {remainder, quotient} with a ready handshake. The execute stage stalls the pipeline while the divider is busy and writes the result into HI/LO. It sits beside the execute stage and is clocked with the core.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  reset rst, synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance.
- operand_1_i  in  32  dividend; sampled at start acceptance.
- operand_2_i  in  32  divisor; sampled at start acceptance.
- start_i  in  1  request; held high by requester until ready_o seen, then dropped.
- annul_i  in  1  abort in-flight division (flush/exception).
- result_o  out  64  [63:32] remainder (to HI), [31:0] quotient (to LO).
- ready_o  out  1  result_o valid.

## Operation
- States: IDLE, BY_ZERO, ON, END. All outputs and state are registered.
- IDLE: if start_i=1 and annul_i=0, latch operands and signedness. Go to BY_ZERO if divisor==0, else ON with counter=0. Otherwise stay.
- Operand prep at acceptance (signed only): a negative operand is replaced by its two's complement. 0x80000000 stays 0x80000000, treated as an unsigned magnitude.
- Working register: 65-bit {partial_rem[32:0], dividend_shift[31:0]}. The upper field is initialised to 0 and the lower field to the dividend magnitude.
- ON, each cycle:
  - Shift left 1.
  - Trial = upper 33 bits minus {1'b0, divisor_mag}.
  - If trial is non-negative, upper takes trial and the new LSB is 1; else the new LSB is 0.
  - counter++. After the 32nd iteration (counter==31 at that edge), go to END.
- Result fixup on entry to END (signed only):
  - Quotient is negated if the dividend and divisor sign bits differ.
  - Remainder is negated if the dividend is negative.
  - Unsigned results are passed through unchanged.
- BY_ZERO: next cycle go to END with result_o=0 (quotient 0, remainder 0).
- END:
  - ready_o=1; result_o holds the final value.
  - While start_i=1, stay in END and hold both outputs.
  - When start_i=0, go to IDLE with ready_o=0 and result_o=0.
- annul_i=1 in ON or BY_ZERO: go to IDLE next edge, ready_o stays 0, result_o=0, no result is produced.
- annul_i in END: ignored; exit is governed by start_i only.
- annul_i in IDLE: blocks acceptance.
- Operand input changes after acceptance have no effect.

## Timing
- Reset (rst=1 at edge): state=IDLE, counter=0, working register=0, ready_o=0, result_o=0. Reset takes priority over annul_i and start_i, including mid-division; no partial result is ever presented.
- Nonzero divisor: start_i accepted at edge t. ON occupies edges t+1..t+32. ready_o=1 first visible after edge t+33. Latency is 33 cycles from acceptance.
- Zero divisor: BY_ZERO after edge t+1, ready_o=1 after edge t+2.
- Back-to-back: after start_i drops in END, the next edge returns to IDLE. A new start_i is accepted no earlier than the following edge; minimum gap is 1 IDLE cycle.
- Requester stall: the requester holds stall_req while start_i=1 and ready_o=0.

## Test plan
- Unsigned 100 / 7, start at t -> ready_o rises after edge t+33; result_o = {32'd2, 32'd14}. Hold start_i 3 more cycles -> result held. Drop start_i -> ready_o=0 and result_o=0 the next cycle.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Boundary: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned same operands -> quotient 0, remainder 0x80000000. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: 1234 / 0 -> ready_o after edge t+2 with result_o=0.
- Annul at 10th ON cycle -> IDLE next edge, ready_o never asserts. Immediate new start 50 / 5 -> {0, 10} at +33.
- rst asserted for one cycle mid-ON (iteration 20) -> all outputs 0, state IDLE. Operand change during ON -> result unaffected. Fresh request completes normally after reset.
